// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arbState_t;

  localparam int DEFAULT_START_TIMEOUT = 4096;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Round-robin selector: first set request bit after lastGrant, wrapping at NUM_REQ.
module rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         lastGrant,
  output logic               found,
  output logic [2:0]         index
);

  logic [NUM_REQ-1:0] candHit;
  logic [2:0]         candIdx [NUM_REQ];

  // Candidate gi is the requester (gi+1) positions after the last grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gCand
    logic [3:0] sum;
    assign sum          = {1'b0, lastGrant} + 4'(gi + 1);
    assign candIdx[gi]  = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
    assign candHit[gi]  = |(req & (NUM_REQ'(1) << candIdx[gi]));
  end

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (candHit[k]) begin
        found = 1'b1;
        index = candIdx[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one Uart8 transmitter between NUM_REQ byte sources with round-robin
// grants, a bounded wait for txBusy, and per-frame completion/timeout pulses.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [8*NUM_REQ-1:0] reqData,
  output logic [NUM_REQ-1:0]   reqReady,
  output logic                 txEn,
  output logic                 txStart,
  output logic [7:0]           txIn,
  input  logic                 txBusy,
  input  logic                 txDone,
  output logic [2:0]           grantId,
  output logic                 sentPulse,
  output logic                 timeoutErr
);

  localparam int                CNT_W    = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  arbState_t          stateReg, stateNext;
  logic [7:0]         txInReg, txInNext;
  logic [2:0]         grantIdReg, grantIdNext;
  logic [2:0]         lastGrantReg, lastGrantNext;
  logic [CNT_W-1:0]   toCntReg, toCntNext;
  logic               sentPulseReg, sentPulseNext;
  logic               timeoutErrReg, timeoutErrNext;
  logic [NUM_REQ-1:0] grantOneHot;
  logic               selFound;
  logic [2:0]         selIndex;
  logic [7:0]         selData;

  rr_select #(.NUM_REQ(NUM_REQ)) uRrSelect (
    .req       (reqValid),
    .lastGrant (lastGrantReg),
    .found     (selFound),
    .index     (selIndex)
  );

  always_comb begin
    selData = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == selIndex) selData = reqData[8*j +: 8];
    end
  end

  always_comb begin
    stateNext      = stateReg;
    txInNext       = txInReg;
    grantIdNext    = grantIdReg;
    lastGrantNext  = lastGrantReg;
    toCntNext      = toCntReg;
    sentPulseNext  = 1'b0;
    timeoutErrNext = 1'b0;
    grantOneHot    = '0;
    case (stateReg)
      IDLE: begin
        // A grant during a reset cycle would be lost, so it is never offered.
        if (!reset && en && selFound) begin
          for (int j = 0; j < NUM_REQ; j++) begin
            if (3'(j) == selIndex) grantOneHot[j] = 1'b1;
          end
          txInNext      = selData;
          grantIdNext   = selIndex;
          lastGrantNext = selIndex;
          toCntNext     = '0;
          stateNext     = START;
        end
      end
      START: begin
        if (txBusy) begin
          stateNext = WAIT_DONE;
        end else if (toCntReg == CNT_LAST) begin
          timeoutErrNext = 1'b1;
          stateNext      = IDLE;
        end else begin
          toCntNext = toCntReg + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (txDone) begin
          sentPulseNext = 1'b1;
          stateNext     = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg      <= IDLE;
      txInReg       <= '0;
      grantIdReg    <= '0;
      lastGrantReg  <= 3'(NUM_REQ - 1);
      toCntReg      <= '0;
      sentPulseReg  <= 1'b0;
      timeoutErrReg <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      txInReg       <= txInNext;
      grantIdReg    <= grantIdNext;
      lastGrantReg  <= lastGrantNext;
      toCntReg      <= toCntNext;
      sentPulseReg  <= sentPulseNext;
      timeoutErrReg <= timeoutErrNext;
    end
  end

  // A frame in flight keeps the transmitter enabled even if en drops.
  assign txEn       = en | (stateReg != IDLE);
  assign txStart    = (stateReg == START);
  assign reqReady   = grantOneHot;
  assign txIn       = txInReg;
  assign grantId    = grantIdReg;
  assign sentPulse  = sentPulseReg;
  assign timeoutErr = timeoutErrReg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: behavioural Uart8 responder, frame scoreboard, vector table
// for round-robin order, and directed sequences for en, timeout and reset corners.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic [NR-1:0]   reqValid = '0;
  logic [8*NR-1:0] reqData = '0;
  logic [NR-1:0]   reqReady;
  logic            txEn;
  logic            txStart;
  logic [7:0]      txIn;
  logic            txBusy = 1'b0;
  logic            txDone = 1'b0;
  logic [2:0]      grantId;
  logic            sentPulse;
  logic            timeoutErr;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqReady   (reqReady),
    .txEn       (txEn),
    .txStart    (txStart),
    .txIn       (txIn),
    .txBusy     (txBusy),
    .txDone     (txDone),
    .grantId    (grantId),
    .sentPulse  (sentPulse),
    .timeoutErr (timeoutErr)
  );

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } frame_t;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          expId;
    logic [7:0]  expByte;
  } vec_t;

  frame_t     expQ[$];
  logic [7:0] rxQ[$];
  int compCnt = 0;
  int errCnt = 0;
  int sentCount = 0;
  int toErrCount = 0;
  int startRun = 0;
  int lastStartLen = 0;
  logic uartStall = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    compCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Uart8 stand-in: accepts txStart, stays busy 4 cycles, then pulses txDone.
  initial begin : uartModel
    int busyLeft;
    logic [7:0] cap;
    busyLeft = 0;
    cap = '0;
    forever begin
      @(posedge clk);
      #1;
      if (txDone) begin
        txDone = 1'b0;
      end else if (txBusy) begin
        busyLeft--;
        if (busyLeft == 0) begin
          txBusy = 1'b0;
          txDone = 1'b1;
          rxQ.push_back(cap);
        end
      end else if (txStart && !uartStall) begin
        txBusy   = 1'b1;
        cap      = txIn;
        busyLeft = 4;
      end
    end
  end

  // Output monitor and scoreboard consumer.
  initial begin : monitor
    frame_t e;
    logic [7:0] r;
    forever begin
      @(posedge clk);
      #3;
      if (txStart) startRun++;
      else if (startRun != 0) begin
        lastStartLen = startRun;
        startRun = 0;
      end
      if (timeoutErr) toErrCount++;
      if (sentPulse) begin
        sentCount++;
        if (expQ.size() == 0 || rxQ.size() == 0) begin
          compCnt++;
          errCnt++;
          $display("FAIL sentPulse: unexpected completion, expQ=%0d rxQ=%0d", expQ.size(), rxQ.size());
        end else begin
          e = expQ.pop_front();
          r = rxQ.pop_front();
          $display("frame id=%0d byte=%02h (expected id=%0d byte=%02h)", grantId, r, e.id, e.data);
          chk("frameId", int'(grantId), int'(e.id));
          chk("frameByte", int'(r), int'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    en = 1'b0;
    reqValid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic waitReady(input string name, input int expMask);
    int n = 0;
    while (reqReady == '0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({name, "_ready"}, int'(reqReady), expMask);
  endtask

  task automatic waitSent(input int target, input string name);
    int n = 0;
    while (sentCount < target && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_sent"}, sentCount, target);
  endtask

  task automatic runFrame(input logic [3:0] v, input logic [31:0] d, input int expId,
                          input logic [7:0] expByte, input string name);
    int base;
    base = sentCount;
    reqData  = d;
    reqValid = v;
    en       = 1'b1;
    expQ.push_back('{3'(expId), expByte});
    #1;
    waitReady(name, 1 << expId);
    tick();
    reqValid = '0;
    waitSent(base + 1, name);
    chk({name, "_startLen"}, lastStartLen, 1);
  endtask

  vec_t vecs[11];
  int base, g, n;

  initial begin : stimulus
    vecs[0]  = '{4'b0001, 32'h0000_008A, 0, 8'h8A};
    vecs[1]  = '{4'b1111, 32'h4433_2211, 1, 8'h22};
    vecs[2]  = '{4'b1111, 32'h4433_2211, 2, 8'h33};
    vecs[3]  = '{4'b1111, 32'h4433_2211, 3, 8'h44};
    vecs[4]  = '{4'b1111, 32'h5566_7788, 0, 8'h88};
    vecs[5]  = '{4'b0001, 32'h0000_00A5, 0, 8'hA5};
    vecs[6]  = '{4'b1000, 32'hD300_0000, 3, 8'hD3};
    vecs[7]  = '{4'b1001, 32'hE400_000F, 0, 8'h0F};
    vecs[8]  = '{4'b0110, 32'h00C2_B100, 1, 8'hB1};
    vecs[9]  = '{4'b0101, 32'h006C_005A, 2, 8'h6C};
    vecs[10] = '{4'b0011, 32'h0000_9F3E, 0, 8'h3E};

    // Reset values
    doReset();
    #1;
    chk("rst_txStart", int'(txStart), 0);
    chk("rst_reqReady", int'(reqReady), 0);
    chk("rst_txIn", int'(txIn), 0);
    chk("rst_grantId", int'(grantId), 0);
    chk("rst_sentPulse", int'(sentPulse), 0);
    chk("rst_timeoutErr", int'(timeoutErr), 0);
    chk("rst_txEn", int'(txEn), 0);
    tick();

    // Round-robin vector table
    for (int i = 0; i < 11; i++) begin
      runFrame(vecs[i].valid, vecs[i].data, vecs[i].expId, vecs[i].expByte, $sformatf("vec%0d", i));
    end

    // All four requesters held valid after reset: 0,1,2,3,0
    doReset();
    base = sentCount;
    reqData  = 32'h4433_2211;
    reqValid = 4'b1111;
    en       = 1'b1;
    expQ.push_back('{3'd0, 8'h11});
    expQ.push_back('{3'd1, 8'h22});
    expQ.push_back('{3'd2, 8'h33});
    expQ.push_back('{3'd3, 8'h44});
    expQ.push_back('{3'd0, 8'h11});
    #1;
    g = 0;
    n = 0;
    while (g < 5 && n < 300) begin
      if (reqReady != '0) g++;
      if (g < 5) begin
        @(posedge clk);
        #2;
        n++;
      end
    end
    chk("rr_grants", g, 5);
    tick();
    reqValid = '0;
    waitSent(base + 5, "rr");

    // en low blocks grants and txEn; raising en grants immediately
    en       = 1'b0;
    reqValid = 4'b0010;
    reqData  = 32'h0000_5500;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("en0_reqReady", int'(reqReady), 0);
      chk("en0_txEn", int'(txEn), 0);
      @(posedge clk);
      #2;
    end
    base = sentCount;
    expQ.push_back('{3'd1, 8'h55});
    en = 1'b1;
    #1;
    chk("en1_reqReady", int'(reqReady), 4'b0010);
    tick();
    reqValid = '0;
    waitSent(base + 1, "en1");

    // en dropped during WAIT_DONE: frame completes, no further grant
    base = sentCount;
    reqData  = 32'h007A_00C9;
    reqValid = 4'b0100;
    en       = 1'b1;
    expQ.push_back('{3'd2, 8'h7A});
    #1;
    waitReady("dropEn", 4'b0100);
    tick();
    reqValid = 4'b0001;
    #1;
    n = 0;
    while (!txBusy && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("dropEn_busy", int'(txBusy), 1);
    tick();
    en = 1'b0;
    #1;
    n = 0;
    while (!sentPulse && n < 50) begin
      chk("dropEn_txEnHold", int'(txEn), 1);
      @(posedge clk);
      #2;
      n++;
    end
    chk("dropEn_sentPulse", int'(sentPulse), 1);
    for (int i = 0; i < 4; i++) begin
      chk("dropEn_noGrant", int'(reqReady), 0);
      chk("dropEn_txEnLow", int'(txEn), 0);
      @(posedge clk);
      #2;
    end
    chk("dropEn_count", sentCount, base + 1);
    base = sentCount;
    expQ.push_back('{3'd0, 8'hC9});
    en = 1'b1;
    #1;
    chk("dropEn_resume", int'(reqReady), 4'b0001);
    tick();
    reqValid = '0;
    waitSent(base + 1, "dropEn_resume");

    // txBusy never arrives: timeout after exactly TO START cycles
    doReset();
    uartStall = 1'b1;
    base = sentCount;
    reqData  = 32'h0000_6655;
    reqValid = 4'b0011;
    en       = 1'b1;
    #1;
    waitReady("timeout_grant", 4'b0001);
    tick();
    reqValid = '0;
    n = 0;
    while (toErrCount == 0 && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_pulse", toErrCount, 1);
    chk("timeout_startLen", lastStartLen, TO);
    chk("timeout_noSent", sentCount, base);
    uartStall = 1'b0;
    reqValid  = 4'b0011;
    expQ.push_back('{3'd1, 8'h66});
    #1;
    waitReady("timeout_next", 4'b0010);
    tick();
    reqValid = '0;
    waitSent(base + 1, "timeout_next");
    chk("timeout_once", toErrCount, 1);

    // Reset during WAIT_DONE abandons the frame; requester 0 wins the next tie
    reqData  = 32'h00BB_0000;
    reqValid = 4'b0100;
    en       = 1'b1;
    #1;
    waitReady("rstMid_grant", 4'b0100);
    tick();
    reqValid = '0;
    #1;
    n = 0;
    while (!txBusy && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("rstMid_busy", int'(txBusy), 1);
    tick();
    base = sentCount;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rstMid_txStart", int'(txStart), 0);
    chk("rstMid_reqReady", int'(reqReady), 0);
    chk("rstMid_grantId", int'(grantId), 0);
    chk("rstMid_txIn", int'(txIn), 0);
    chk("rstMid_sentPulse", int'(sentPulse), 0);
    chk("rstMid_timeoutErr", int'(timeoutErr), 0);
    chk("rstMid_txEn", int'(txEn), 1);
    n = 0;
    while ((txBusy || txDone || n < 6) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("rstMid_noSent", sentCount, base);
    chk("rstMid_noTimeout", toErrCount, 1);
    rxQ.delete();
    reqData  = 32'hDDCC_BBAA;
    reqValid = 4'b1111;
    expQ.push_back('{3'd0, 8'hAA});
    #1;
    chk("rstMid_tie", int'(reqReady), 4'b0001);
    tick();
    reqValid = '0;
    waitSent(base + 1, "rstMid_tie");

    chk("expQ_empty", expQ.size(), 0);
    chk("rxQ_empty", rxQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
    $finish;
  end

endmodule
